// File: rtl/full_adder_1b_if.sv
// Operand/result bundle for the 1-bit full adder.
// master drives operands, slave returns sum/carry.
interface full_adder_1b_if;
    logic a;
    logic b;
    logic cin;
    logic chain;
    logic in_valid;
    logic s;
    logic cout;
    logic out_valid;

    modport master (
        output a,
        output b,
        output cin,
        output chain,
        output in_valid,
        input  s,
        input  cout,
        input  out_valid
    );

    modport slave (
        input  a,
        input  b,
        input  cin,
        input  chain,
        input  in_valid,
        output s,
        output cout,
        output out_valid
    );
endinterface

// File: rtl/full_adder_1b.sv
// 1-bit full adder with stored carry for bit-serial chaining.
// REGISTER_OUT selects registered (1 cycle) or combinational results.
module full_adder_1b #(
    parameter bit REGISTER_OUT = 1'b1
) (
    input logic           clk,
    input logic           rst,
    full_adder_1b_if.slave bus
);

    logic carry_q;
    logic ci_eff;
    logic sum;
    logic carry;

    always_comb begin
        ci_eff = bus.chain ? carry_q : bus.cin;
        sum    = bus.a ^ bus.b ^ ci_eff;
        carry  = (bus.a & bus.b)
               | (bus.a & ci_eff)
               | (bus.b & ci_eff);
    end

    // Stored carry only advances on accepted vectors, so bubbles keep it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            carry_q <= 1'b0;
        end else if (bus.in_valid) begin
            carry_q <= carry;
        end
    end

    generate
        if (REGISTER_OUT) begin : g_reg
            logic s_q;
            logic cout_q;
            logic ov_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s_q    <= 1'b0;
                    cout_q <= 1'b0;
                    ov_q   <= 1'b0;
                end else begin
                    ov_q <= bus.in_valid;
                    if (bus.in_valid) begin
                        s_q    <= sum;
                        cout_q <= carry;
                    end
                end
            end

            assign bus.s         = s_q;
            assign bus.cout      = cout_q;
            assign bus.out_valid = ov_q;
        end else begin : g_comb
            assign bus.s         = sum;
            assign bus.cout      = carry;
            assign bus.out_valid = bus.in_valid;
        end
    endgenerate

endmodule

// File: tb/tb_full_adder_1b.sv
// Bench for full_adder_1b: registered and combinational variants
// driven side by side against an arithmetic reference model.
module tb_full_adder_1b;

    logic clk;
    logic rst;

    full_adder_1b_if fr ();
    full_adder_1b_if fc ();

    full_adder_1b #(.REGISTER_OUT(1'b1)) dut_r (
        .clk (clk),
        .rst (rst),
        .bus (fr.slave)
    );

    full_adder_1b #(.REGISTER_OUT(1'b0)) dut_c (
        .clk (clk),
        .rst (rst),
        .bus (fc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int passed;

    // reference state: stored carry and registered outputs
    bit m_carry;
    bit m_s;
    bit m_cout;
    bit m_ov;

    task automatic chk(input string tag, input logic obs,
                       input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic drive(input bit a, input bit b, input bit cin,
                         input bit chain, input bit v);
        fr.a = a; fr.b = b; fr.cin = cin;
        fr.chain = chain; fr.in_valid = v;
        fc.a = a; fc.b = b; fc.cin = cin;
        fc.chain = chain; fc.in_valid = v;
    endtask

    task automatic check_reg(input string tag);
        chk({tag, "_rs"},  fr.s,         m_s);
        chk({tag, "_rc"},  fr.cout,      m_cout);
        chk({tag, "_rov"}, fr.out_valid, m_ov);
    endtask

    // One clock: drive, check combinational result, clock, check registered.
    task automatic cycle(input string tag, input bit a, input bit b,
                         input bit cin, input bit chain, input bit v);
        int tot;
        drive(a, b, cin, chain, v);
        tot = int'(a) + int'(b) + int'(chain ? m_carry : cin);
        #1;
        chk({tag, "_cs"},  fc.s,         tot[0]);
        chk({tag, "_cc"},  fc.cout,      tot[1]);
        chk({tag, "_cov"}, fc.out_valid, v);
        @(posedge clk);
        m_ov = v;
        if (v) begin
            m_carry = tot[1];
            m_s     = tot[0];
            m_cout  = tot[1];
        end
        #1;
        check_reg(tag);
    endtask

    task automatic model_reset();
        m_carry = 1'b0;
        m_s     = 1'b0;
        m_cout  = 1'b0;
        m_ov    = 1'b0;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        model_reset();
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        #2;
        check_reg("reset");
        #11;
        rst = 1'b0;

        // truth table, one vector per cycle
        for (int i = 0; i < 8; i++) begin
            bit [2:0] v;
            v = 3'(i);
            cycle($sformatf("tt%0d", i), v[2], v[1], v[0], 0, 1);
        end
        chk("tt_last_s", fr.s, 1'b1);
        chk("tt_last_c", fr.cout, 1'b1);

        // 3 + 1 bit-serial from a fresh reset
        rst = 1'b1;
        model_reset();
        #2;
        rst = 1'b0;
        cycle("ser0", 1, 1, 0, 1, 1);
        chk("ser0_cout", fr.cout, 1'b1);
        cycle("ser1", 1, 0, 0, 1, 1);
        chk("ser1_s", fr.s, 1'b0);
        chk("ser1_c", fr.cout, 1'b1);

        // carry held across an idle bubble
        cycle("bub0", 1, 1, 0, 0, 1);
        cycle("bub1", 0, 0, 0, 1, 0);
        cycle("bub2", 0, 0, 0, 1, 1);
        chk("bub2_s", fr.s, 1'b1);
        chk("bub2_c", fr.cout, 1'b0);

        // asynchronous reset between edges
        cycle("ar0", 1, 1, 1, 0, 1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_reg("ar_async");
        chk("ar_comb_s", fc.s, 1'b1);
        chk("ar_comb_c", fc.cout, 1'b1);
        chk("ar_comb_ov", fc.out_valid, 1'b1);
        #2;
        rst = 1'b0;
        cycle("ar1", 0, 0, 0, 1, 1);
        chk("ar1_s", fr.s, 1'b0);

        // valid vector followed by idle cycles holds s/cout
        cycle("hold0", 1, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cycle($sformatf("hold%0d", i + 1), 0, 0, 0, 0, 0);
            chk("hold_ov", fr.out_valid, 1'b0);
            chk("hold_s", fr.s, 1'b0);
            chk("hold_c", fr.cout, 1'b1);
        end

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            bit ra, rb, rc, rch, rv;
            ra  = 1'($urandom);
            rb  = 1'($urandom);
            rc  = 1'($urandom);
            rch = 1'($urandom);
            rv  = ($urandom_range(0, 3) != 0);
            cycle($sformatf("rnd%0d", i), ra, rb, rc, rch, rv);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
